// File: rtl/jb_cs_pkg.sv
// Shared definitions for the chip-select sequencer.
//   cs_state_e : sequencer FSM states (IDLE -> ASSERT -> GAP -> IDLE)
//   onehot()   : builds a CS image with a single asserted line in the
//                requested polarity; bits at or above 'width' are never
//                asserted so callers may truncate the result freely.
package jb_cs_pkg;

  localparam int unsigned CS_MAX = 256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } cs_state_e;

  function automatic logic [CS_MAX-1:0] onehot(input logic [7:0]  idx,
                                               input int unsigned width,
                                               input bit          active_low);
    logic [CS_MAX-1:0] v;
    v = '0;
    if (32'(idx) < width) v[idx] = 1'b1;
    if (active_low) v = ~v;
    return v;
  endfunction

endpackage

// File: rtl/jb_rr_pick.sv
// Round-robin picker: finds the first set bit of 'mask' strictly after
// 'ptr', wrapping from NCS-1 back to 0. The pointer position itself is the
// last candidate examined, so a mask holding only that bit still matches.
//   mask  in  NCS    eligible slaves, bit i = index i
//   ptr   in  SEL_W  index of the most recently scanned slave
//   idx   out SEL_W  chosen index (0 when nothing found)
//   found out 1      mask has at least one set bit
module jb_rr_pick #(
  parameter  int unsigned SEL_W = 3,
  localparam int unsigned NCS   = 2**SEL_W
) (
  input  logic [NCS-1:0]   mask,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [SEL_W-1:0] w_cand;

  // Candidate arithmetic is SEL_W wide, so the add wraps modulo NCS on its own.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    w_cand = '0;
    for (int unsigned k = 1; k <= NCS; k++) begin
      w_cand = ptr + SEL_W'(k);
      if (!found && mask[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/jb_cs_sequencer.sv
// Registered N-to-2^N chip-select sequencer for regmap slave selection.
// A host request (valid/ready) or, failing that, a round-robin scan over
// scan_mask selects one slave; its CS line is asserted for H cycles
// (H = max(hold,1)), followed by a done pulse and GAP_CYC idle cycles.
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   req_valid  in   1      host request valid
//   req_ready  out  1      request accepted this cycle if valid (IDLE only)
//   req_sel    in   SEL_W  CS index to assert
//   req_hold   in   CNT_W  assert length in cycles, 0 treated as 1
//   scan_en    in   1      enable round-robin scan when no host request
//   scan_mask  in   NCS    slaves eligible for scan
//   cs         out  NCS    chip selects, polarity per ACTIVE_LOW
//   cs_active  out  1      high while a CS line is asserted
//   cs_idx     out  SEL_W  index of the current/last asserted CS
//   done       out  1      one-cycle pulse on the cycle CS deasserts
module jb_cs_sequencer
  import jb_cs_pkg::*;
#(
  parameter  int unsigned SEL_W      = 3,
  parameter  int          ACTIVE_LOW = 1,
  parameter  int unsigned CNT_W      = 8,
  parameter  int unsigned GAP_CYC    = 1,
  localparam int unsigned NCS        = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SEL_W-1:0] req_sel,
  input  logic [CNT_W-1:0] req_hold,
  input  logic             scan_en,
  input  logic [NCS-1:0]   scan_mask,
  output logic [NCS-1:0]   cs,
  output logic             cs_active,
  output logic [SEL_W-1:0] cs_idx,
  output logic             done
);

  localparam logic [NCS-1:0] CS_IDLE  = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam int unsigned    GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0]  GAP_LOAD = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  cs_state_e        r_state;
  logic [NCS-1:0]   r_cs;
  logic             r_active;
  logic [SEL_W-1:0] r_idx;
  logic             r_done;
  logic             r_ready;
  logic [SEL_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [GW-1:0]    r_gap;

  logic             w_accept;
  logic             w_found;
  logic [SEL_W-1:0] w_pick_idx;
  logic [SEL_W-1:0] w_next_idx;
  logic [CNT_W-1:0] w_hold_m1;
  logic [NCS-1:0]   w_next_img;

  jb_rr_pick #(
    .SEL_W(SEL_W)
  ) u_pick (
    .mask  (scan_mask),
    .ptr   (r_ptr),
    .idx   (w_pick_idx),
    .found (w_found)
  );

  assign w_accept   = req_valid && r_ready;
  assign w_next_idx = w_accept ? req_sel : w_pick_idx;
  // Counter holds H-1 so the ASSERT state lasts exactly H cycles.
  assign w_hold_m1  = (req_hold == '0) ? '0 : req_hold - CNT_W'(1);
  assign w_next_img = NCS'(onehot(8'(w_next_idx), NCS, ACTIVE_LOW != 0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cs     <= CS_IDLE;
      r_active <= 1'b0;
      r_idx    <= '0;
      r_done   <= 1'b0;
      r_ready  <= 1'b0;
      r_ptr    <= '1;
      r_cnt    <= '0;
      r_gap    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept || (scan_en && w_found)) begin
            r_state  <= ST_ASSERT;
            r_cs     <= w_next_img;
            r_active <= 1'b1;
            r_idx    <= w_next_idx;
            r_cnt    <= w_hold_m1;
            r_ready  <= 1'b0;
            // Only scan-initiated accesses advance the round-robin pointer.
            if (!w_accept) r_ptr <= w_pick_idx;
          end else begin
            r_ready <= 1'b1;
          end
        end
        ST_ASSERT: begin
          if (r_cnt == '0) begin
            r_cs     <= CS_IDLE;
            r_active <= 1'b0;
            r_done   <= 1'b1;
            if (GAP_CYC == 0) begin
              r_state <= ST_IDLE;
              r_ready <= 1'b1;
            end else begin
              r_state <= ST_GAP;
              r_gap   <= GAP_LOAD;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (r_gap == '0) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_gap <= r_gap - GW'(1);
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_cs     <= CS_IDLE;
          r_active <= 1'b0;
          r_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign cs        = r_cs;
  assign cs_active = r_active;
  assign cs_idx    = r_idx;
  assign done      = r_done;
  assign req_ready = r_ready;

endmodule

// File: tb/tb_jb_cs_sequencer.sv
// Testbench for jb_cs_sequencer. Instance 'a' uses default parameters
// (active-low CS, one gap cycle); instance 'b' uses active-high CS with no
// gap. Outputs are sampled on the falling edge; inputs change right after.
module tb_jb_cs_sequencer;

  localparam int GAP = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       a_valid, a_ready, a_scan, a_active, a_done;
  logic [2:0] a_sel, a_idx;
  logic [7:0] a_hold, a_mask, a_cs;

  logic       b_valid, b_ready, b_scan, b_active, b_done;
  logic [2:0] b_sel, b_idx;
  logic [7:0] b_hold, b_mask, b_cs;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jb_cs_sequencer #(
    .SEL_W(3), .ACTIVE_LOW(1), .CNT_W(8), .GAP_CYC(1)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_valid), .req_ready(a_ready), .req_sel(a_sel), .req_hold(a_hold),
    .scan_en(a_scan), .scan_mask(a_mask),
    .cs(a_cs), .cs_active(a_active), .cs_idx(a_idx), .done(a_done)
  );

  jb_cs_sequencer #(
    .SEL_W(3), .ACTIVE_LOW(0), .CNT_W(8), .GAP_CYC(0)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_valid), .req_ready(b_ready), .req_sel(b_sel), .req_hold(b_hold),
    .scan_en(b_scan), .scan_mask(b_mask),
    .cs(b_cs), .cs_active(b_active), .cs_idx(b_idx), .done(b_done)
  );

  // Expected CS image: single line driven to the asserted level.
  function automatic logic [7:0] cs_img(input int idx, input bit al);
    logic [7:0] v;
    v = 8'(32'd1 << idx);
    return al ? ~v : v;
  endfunction

  function automatic int n_asserted(input logic [7:0] c, input bit al);
    int n = 0;
    for (int i = 0; i < 8; i++) if (c[i] == !al) n++;
    return n;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    a_valid = 0; a_sel = '0; a_hold = '0; a_scan = 0; a_mask = '0;
    b_valid = 0; b_sel = '0; b_hold = '0; b_scan = 0; b_mask = '0;
    repeat (3) @(negedge clk);
    n_vec++; if (a_cs !== 8'hFF) begin n_err++; $display("FAIL reset_cs_a: got %h want ff", a_cs); end
    n_vec++; if (b_cs !== 8'h00) begin n_err++; $display("FAIL reset_cs_b: got %h want 00", b_cs); end
    n_vec++; if (a_active !== 1'b0 || a_done !== 1'b0 || a_idx !== 3'd0)
      begin n_err++; $display("FAIL reset_misc: active=%b done=%b idx=%0d want 0/0/0", a_active, a_done, a_idx); end
    n_vec++; if (a_ready !== 1'b0 || b_ready !== 1'b0)
      begin n_err++; $display("FAIL reset_ready: got %b/%b want 0/0", a_ready, b_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (a_ready !== 1'b1 || b_ready !== 1'b1)
      begin n_err++; $display("FAIL release_ready: got %b/%b want 1/1", a_ready, b_ready); end
  endtask

  task automatic test_single();
    logic [7:0] exp_cs;
    a_valid = 1; a_sel = 3'd5; a_hold = 8'd3;
    @(negedge clk);
    a_valid = 0; a_sel = 3'($urandom_range(0, 7)); a_hold = 8'($urandom_range(0, 255));
    for (int i = 0; i < 6; i++) begin
      exp_cs = (i < 3) ? 8'b1101_1111 : 8'hFF;
      n_vec++; if (a_cs !== exp_cs) begin n_err++; $display("FAIL single_cs[%0d]: got %b want %b", i, a_cs, exp_cs); end
      n_vec++; if (a_done !== (i == 3)) begin n_err++; $display("FAIL single_done[%0d]: got %b want %b", i, a_done, (i == 3)); end
      n_vec++; if (a_ready !== (i >= 4)) begin n_err++; $display("FAIL single_ready[%0d]: got %b want %b", i, a_ready, (i >= 4)); end
      n_vec++; if (a_active !== (i < 3) || a_idx !== 3'd5)
        begin n_err++; $display("FAIL single_stat[%0d]: active=%b idx=%0d want %b/5", i, a_active, a_idx, (i < 3)); end
      @(negedge clk);
    end
  endtask

  task automatic test_max_hold();
    int  n_on = 0;
    bit  seen = 0;
    a_valid = 1; a_sel = 3'd1; a_hold = 8'hFF;
    @(negedge clk);
    a_valid = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (a_cs === cs_img(1, 1'b1)) n_on++;
      if (a_done === 1'b1) seen = 1;
      else @(negedge clk);
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL max_hold_timeout: done not seen within 300 cycles"); end
    n_vec++; if (n_on != 255) begin n_err++; $display("FAIL max_hold_len: got %0d cycles want 255", n_on); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_active_high();
    b_valid = 1; b_sel = 3'd0; b_hold = 8'd0;
    @(negedge clk);
    b_valid = 0;
    n_vec++; if (b_cs !== 8'h01 || b_active !== 1'b1 || b_ready !== 1'b0)
      begin n_err++; $display("FAIL ah_assert: cs=%h act=%b rdy=%b want 01/1/0", b_cs, b_active, b_ready); end
    @(negedge clk);
    n_vec++; if (b_cs !== 8'h00 || b_done !== 1'b1 || b_ready !== 1'b1)
      begin n_err++; $display("FAIL ah_done: cs=%h done=%b rdy=%b want 00/1/1", b_cs, b_done, b_ready); end
    @(negedge clk);
    n_vec++; if (b_cs !== 8'h00 || b_done !== 1'b0)
      begin n_err++; $display("FAIL ah_after: cs=%h done=%b want 00/0", b_cs, b_done); end
  endtask

  // Pointer is at 7 here: only host accepts have happened since reset.
  task automatic test_scan();
    int         seq[4] = '{0, 2, 7, 0};
    int         rel, k, ph;
    logic [7:0] exp_cs;
    logic [2:0] exp_idx;
    bit         exp_done, exp_ready;
    a_hold = 8'd2; a_mask = 8'b1000_0101; a_scan = 1; a_valid = 0;
    for (int t = 1; t <= 18; t++) begin
      @(negedge clk);
      rel = t - 1; k = rel / 4; ph = rel % 4;
      if (k < 4) begin
        exp_cs = (ph < 2) ? cs_img(seq[k], 1'b1) : 8'hFF;
        exp_done = (ph == 2); exp_ready = (ph == 3); exp_idx = 3'(seq[k]);
      end else begin
        exp_cs = 8'hFF; exp_done = 0; exp_ready = 1; exp_idx = 3'(seq[3]);
      end
      n_vec++; if (a_cs !== exp_cs) begin n_err++; $display("FAIL scan_cs[%0d]: got %b want %b", t, a_cs, exp_cs); end
      n_vec++; if (a_done !== exp_done || a_ready !== exp_ready)
        begin n_err++; $display("FAIL scan_hs[%0d]: done=%b rdy=%b want %b/%b", t, a_done, a_ready, exp_done, exp_ready); end
      n_vec++; if (a_idx !== exp_idx) begin n_err++; $display("FAIL scan_idx[%0d]: got %0d want %0d", t, a_idx, exp_idx); end
      if (t == 13) begin a_scan = 0; a_mask = 8'($urandom_range(0, 255)); end
    end
  endtask

  // Pointer is at 0 here; host wins, then scan resumes after 0 -> index 2.
  task automatic test_priority();
    a_mask = 8'b1000_0101; a_hold = 8'd1; a_scan = 1; a_valid = 1; a_sel = 3'd3;
    @(negedge clk);
    a_valid = 0;
    n_vec++; if (a_cs !== cs_img(3, 1'b1) || a_idx !== 3'd3)
      begin n_err++; $display("FAIL prio_host: cs=%b idx=%0d want %b/3", a_cs, a_idx, cs_img(3, 1'b1)); end
    @(negedge clk);
    n_vec++; if (a_cs !== 8'hFF || a_done !== 1'b1)
      begin n_err++; $display("FAIL prio_done: cs=%b done=%b want ff/1", a_cs, a_done); end
    @(negedge clk);
    n_vec++; if (a_ready !== 1'b1 || a_cs !== 8'hFF)
      begin n_err++; $display("FAIL prio_gap: rdy=%b cs=%b want 1/ff", a_ready, a_cs); end
    @(negedge clk);
    n_vec++; if (a_cs !== cs_img(2, 1'b1) || a_idx !== 3'd2)
      begin n_err++; $display("FAIL prio_scan: cs=%b idx=%0d want %b/2", a_cs, a_idx, cs_img(2, 1'b1)); end
    a_scan = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    a_valid = 1; a_sel = 3'd6; a_hold = 8'd10;
    @(negedge clk);
    a_valid = 0;
    repeat (2) @(negedge clk);
    n_vec++; if (a_cs !== cs_img(6, 1'b1)) begin n_err++; $display("FAIL rmid_pre: got %b want %b", a_cs, cs_img(6, 1'b1)); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (a_cs !== 8'hFF || a_active !== 1'b0 || a_done !== 1'b0)
      begin n_err++; $display("FAIL rmid_async: cs=%b act=%b done=%b want ff/0/0", a_cs, a_active, a_done); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (a_ready !== 1'b1 || a_done !== 1'b0 || a_cs !== 8'hFF)
      begin n_err++; $display("FAIL rmid_release: rdy=%b done=%b cs=%b want 1/0/ff", a_ready, a_done, a_cs); end
  endtask

  // Random stress against a timeline model: an access accepted at edge a
  // drives CS in slots a..a+H-1, pulses done at a+H, and frees the block at
  // a+H+GAP. Slot s is the falling edge after s rising edges since release.
  task automatic test_back_to_back();
    int         m_a = -100, m_h = 0, m_idx = 0, m_ptr = 7;
    int         m_idle_from = 0, m_ready_from = 1;
    int         last_off = -100, h, p;
    bit         prev_on = 0, exp_on;
    logic [7:0] exp_cs;
    rst_n = 1'b0;
    a_valid = 0; a_scan = 0; a_mask = '0; a_hold = '0; a_sel = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 600; s++) begin
      exp_on = (s >= m_a) && (s < m_a + m_h);
      exp_cs = exp_on ? cs_img(m_idx, 1'b1) : 8'hFF;
      n_vec++; if (a_cs !== exp_cs) begin n_err++; $display("FAIL b2b_cs[%0d]: got %b want %b", s, a_cs, exp_cs); end
      n_vec++; if (a_done !== (s == m_a + m_h) || a_ready !== (s >= m_ready_from))
        begin n_err++; $display("FAIL b2b_hs[%0d]: done=%b rdy=%b want %b/%b", s, a_done, a_ready, (s == m_a + m_h), (s >= m_ready_from)); end
      n_vec++; if (a_active !== exp_on || a_idx !== 3'(m_idx))
        begin n_err++; $display("FAIL b2b_stat[%0d]: act=%b idx=%0d want %b/%0d", s, a_active, a_idx, exp_on, m_idx); end
      n_vec++; if (n_asserted(a_cs, 1'b1) > 1) begin n_err++; $display("FAIL b2b_onehot[%0d]: cs=%b", s, a_cs); end
      if (n_asserted(a_cs, 1'b1) == 1 && !prev_on) begin
        n_vec++; if (s - last_off < GAP + 1)
          begin n_err++; $display("FAIL b2b_spacing[%0d]: got %0d want >=%0d", s, s - last_off, GAP + 1); end
      end
      if (n_asserted(a_cs, 1'b1) == 0 && prev_on) last_off = s;
      prev_on = (n_asserted(a_cs, 1'b1) == 1);

      a_valid = ($urandom_range(0, 99) < 60);
      a_sel   = 3'($urandom_range(0, 7));
      a_hold  = 8'($urandom_range(0, 4));
      a_scan  = ($urandom_range(0, 99) < 40);
      a_mask  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));

      h = (a_hold == 0) ? 1 : int'(a_hold);
      if (s >= m_idle_from) begin
        if (a_valid && s >= m_ready_from) begin
          m_a = s + 1; m_h = h; m_idx = int'(a_sel);
          m_idle_from = m_a + m_h + GAP; m_ready_from = m_idle_from;
        end else if (a_scan && a_mask != 0) begin
          p = -1;
          for (int k = 1; k <= 8 && p < 0; k++)
            if (a_mask[(m_ptr + k) % 8]) p = (m_ptr + k) % 8;
          m_ptr = p;
          m_a = s + 1; m_h = h; m_idx = p;
          m_idle_from = m_a + m_h + GAP; m_ready_from = m_idle_from;
        end
      end
      @(negedge clk);
    end
    a_valid = 0; a_scan = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_max_hold();
    test_active_high();
    test_scan();
    test_priority();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
